// File: rtl/sent_tx_crc_gen.sv
// SENT transmit-side CRC generator.
// Captures a fast-channel, short-serial or enhanced-serial payload on a start
// pulse and computes its CRC bit-serially, MSB first. The payload is followed
// by zero augmentation bits, and the LFSR starts from the standard seed.
// Produces CRC-4 for fast and short-serial frames, CRC-6 for enhanced serial.
module sent_tx_crc_gen #(
  parameter logic [3:0] SEED4 = 4'b0101,
  parameter logic [3:0] POLY4 = 4'b1101,
  parameter logic [5:0] SEED6 = 6'b010101,
  parameter logic [5:0] POLY6 = 6'b011001
) (
  input  logic        clk_tx,
  input  logic        reset_n_tx,
  input  logic        start_i,
  input  logic [1:0]  mode_i,
  input  logic [2:0]  nibble_num_i,
  input  logic [23:0] data_i,
  output logic        busy_o,
  output logic [5:0]  crc_o,
  output logic        crc_done_o,
  output logic        err_o
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state_reg;
  logic [5:0]  lfsr_reg;
  logic [29:0] sr_reg;      // payload left-justified at bit 29, zeros behind it
  logic [4:0]  cnt_reg;     // bits still to process, augmentation included
  logic        wide_reg;    // 1 = CRC-6 run, 0 = CRC-4 run
  logic        busy_reg;
  logic [5:0]  crc_reg;
  logic        done_reg;
  logic        err_reg;

  logic        req_illegal;
  logic [29:0] load_sr;
  logic [4:0]  load_cnt;
  logic        load_wide;
  logic [5:0]  load_seed;
  logic        bit_in;
  logic [5:0]  lfsr_next;

  // Decode a request into shift-register image, bit count and CRC width
  always_comb begin
    req_illegal = (mode_i == 2'b11) ||
                  ((mode_i == 2'b00) && ((nibble_num_i == 3'd0) || (nibble_num_i == 3'd7)));
    load_sr   = '0;
    load_cnt  = '0;
    load_wide = 1'b0;
    load_seed = {2'b00, SEED4};
    case (mode_i)
      2'b00: begin
        load_cnt = {nibble_num_i, 2'b00} + 5'd4;
        case (nibble_num_i)
          3'd1:    load_sr = {data_i[3:0],  26'd0};
          3'd2:    load_sr = {data_i[7:0],  22'd0};
          3'd3:    load_sr = {data_i[11:0], 18'd0};
          3'd4:    load_sr = {data_i[15:0], 14'd0};
          3'd5:    load_sr = {data_i[19:0], 10'd0};
          3'd6:    load_sr = {data_i[23:0], 6'd0};
          default: load_sr = '0;
        endcase
      end
      2'b01: begin
        load_cnt = 5'd16;
        load_sr  = {data_i[11:0], 18'd0};
      end
      2'b10: begin
        load_cnt  = 5'd30;
        load_sr   = {data_i[23:0], 6'd0};
        load_wide = 1'b1;
        load_seed = SEED6;
      end
      default: begin
        load_cnt = '0;
      end
    endcase
  end

  // One LFSR step: shift in the next payload bit, fold in the polynomial on carry-out
  always_comb begin
    bit_in = sr_reg[29];
    if (wide_reg) begin
      lfsr_next = {lfsr_reg[4:0], bit_in} ^ (lfsr_reg[5] ? POLY6 : 6'd0);
    end else begin
      lfsr_next = {2'b00, ({lfsr_reg[2:0], bit_in} ^ (lfsr_reg[3] ? POLY4 : 4'd0))};
    end
  end

  // Control FSM: accept requests in IDLE, process one bit per clock in SHIFT
  always_ff @(posedge clk_tx) begin
    if (!reset_n_tx) begin
      state_reg <= IDLE;
      lfsr_reg  <= '0;
      sr_reg    <= '0;
      cnt_reg   <= '0;
      wide_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      crc_reg   <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            if (req_illegal) begin
              err_reg <= 1'b1;
            end else begin
              lfsr_reg  <= load_seed;
              sr_reg    <= load_sr;
              cnt_reg   <= load_cnt;
              wide_reg  <= load_wide;
              busy_reg  <= 1'b1;
              state_reg <= SHIFT;
            end
          end
        end
        SHIFT: begin
          lfsr_reg <= lfsr_next;
          sr_reg   <= {sr_reg[28:0], 1'b0};
          cnt_reg  <= cnt_reg - 5'd1;
          if (cnt_reg == 5'd1) begin
            crc_reg   <= lfsr_next;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy_o     = busy_reg;
  assign crc_o      = crc_reg;
  assign crc_done_o = done_reg;
  assign err_o      = err_reg;

endmodule
